// File: rtl/mem_port_arbiter.sv
// Shares one memory port between MR reads and MW writes, one transaction at a time, alternating on conflict.
// Grant on the request edge, ack one cycle after completion; requesters stall combinationally until their ack.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        r,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        rd_stall,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        wr_stall,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        read_finished,
  input  logic        write_finished,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             last_wr, last_wr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_live, wr_live;
  logic             grant_rd, grant_wr;
  logic             rd_done, wr_done, expire;

  // A request seen in its own ack cycle is the one just served, not a new one.
  assign rd_live = rd_req & ~rd_ack;
  assign wr_live = wr_req & ~wr_ack;

  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    cnt_nxt     = cnt;
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    rd_done     = 1'b0;
    wr_done     = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_live && (!rd_live || !last_wr)) begin
          grant_wr    = 1'b1;
          state_nxt   = WR;
          last_wr_nxt = 1'b1;
          cnt_nxt     = '0;
        end else if (rd_live) begin
          grant_rd    = 1'b1;
          state_nxt   = RD;
          last_wr_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end
      RD: begin
        if (read_finished) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WR: begin
        if (write_finished) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state   <= IDLE;
      last_wr <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      last_wr <= last_wr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_data     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      rd_ack <= rd_done;
      wr_ack <= wr_done;
      if (rd_done)  rd_data   <= mem_rdata;
      if (grant_wr) mem_addr  <= wr_addr;
      if (grant_rd) mem_addr  <= rd_addr;
      if (grant_wr) mem_wdata <= wr_data;
      if (expire)   timeout_err <= 1'b1;
    end
  end

  assign mem_re   = (state == RD);
  assign mem_we   = (state == WR);
  assign busy     = (state != IDLE);
  assign rd_stall = rd_req & ~rd_ack;
  assign wr_stall = wr_req & ~wr_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem_rdata = '0;
  logic        read_finished = 1'b0;
  logic        write_finished = 1'b0;
  logic        rd_ack, rd_stall, wr_ack, wr_stall, mem_re, mem_we, busy, timeout_err;
  logic [31:0] rd_data, mem_addr, mem_wdata;

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .r(r),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_stall(rd_stall),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_stall(wr_stall),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .read_finished(read_finished), .write_finished(write_finished),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the port (0 none, 1 read, 2 write) and how long it has waited.
  int          own = 0;
  int          waited = 0;
  bit          last_w = 1'b0;
  bit          e_rd_ack = 1'b0, e_wr_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

  always @(posedge clk or negedge r) begin : model
    bit rdv, wrv;
    if (!r) begin
      own = 0; waited = 0; last_w = 1'b0;
      e_rd_ack = 1'b0; e_wr_ack = 1'b0; e_err = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      rdv = rd_req && !e_rd_ack;
      wrv = wr_req && !e_wr_ack;
      e_rd_ack = 1'b0;
      e_wr_ack = 1'b0;
      if (own == 0) begin
        if (wrv && !(rdv && last_w)) begin
          own = 2; e_addr = wr_addr; e_wdata = wr_data; last_w = 1'b1; waited = 0;
        end else if (rdv) begin
          own = 1; e_addr = rd_addr; last_w = 1'b0; waited = 0;
        end
      end else if ((own == 1 && read_finished) || (own == 2 && write_finished)) begin
        if (own == 1) begin
          e_rdata = mem_rdata;
          e_rd_ack = 1'b1;
        end else begin
          e_wr_ack = 1'b1;
        end
        own = 0;
      end else begin
        waited++;
        if (waited == TO) begin
          own = 0;
          e_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("busy", busy, own != 0);
    chk("mem_re", mem_re, own == 1);
    chk("mem_we", mem_we, own == 2);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("rd_ack", rd_ack, e_rd_ack);
    chk("wr_ack", wr_ack, e_wr_ack);
    chk("rd_data", rd_data, e_rdata);
    chk("timeout_err", timeout_err, e_err);
    chk("rd_stall", rd_stall, rd_req && !e_rd_ack);
    chk("wr_stall", wr_stall, wr_req && !e_wr_ack);
  end

  task automatic quiet();
    rd_req = 1'b0; wr_req = 1'b0; read_finished = 1'b0; write_finished = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    r = 1'b0;
    @(negedge clk);
    r = 1'b1;
  endtask

  initial begin
    bit [7:0] seq;
    int       ng;
    bit       pw, pr;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst timeout_err", timeout_err, 0);
    r = 1'b1;

    // Single read
    rd_req = 1'b1; rd_addr = 32'h100;
    @(negedge clk);
    chk("rd1 mem_re", mem_re, 1);
    chk("rd1 mem_addr", mem_addr, 32'h100);
    chk("rd1 stall", rd_stall, 1);
    @(negedge clk);
    chk("rd1 mem_re 2nd", mem_re, 1);
    read_finished = 1'b1; mem_rdata = 32'hABCD;
    @(negedge clk);
    chk("rd1 ack", rd_ack, 1);
    chk("rd1 data", rd_data, 32'hABCD);
    chk("rd1 stall in ack", rd_stall, 0);
    chk("rd1 mem_re off", mem_re, 0);
    chk("model rdata", e_rdata, 32'hABCD);
    quiet();

    // Conflict after reset: write wins first
    do_reset();
    rd_req = 1'b1; rd_addr = 32'h300; wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'h55;
    @(negedge clk);
    chk("cf mem_we", mem_we, 1);
    chk("cf mem_wdata", mem_wdata, 32'h55);
    chk("cf mem_addr", mem_addr, 32'h200);
    chk("cf rd_stall", rd_stall, 1);
    write_finished = 1'b1;
    @(negedge clk);
    chk("cf wr_ack", wr_ack, 1);
    chk("cf rd_stall 2", rd_stall, 1);
    wr_req = 1'b0; write_finished = 1'b0;
    @(negedge clk);
    chk("cf then mem_re", mem_re, 1);
    chk("cf then addr", mem_addr, 32'h300);
    chk("cf rd_stall 3", rd_stall, 1);
    read_finished = 1'b1;
    @(negedge clk);
    chk("cf rd_ack", rd_ack, 1);
    quiet();

    // Fairness under continuous contention
    do_reset();
    rd_req = 1'b1; wr_req = 1'b1; read_finished = 1'b1; write_finished = 1'b1;
    seq = '0; ng = 0; pw = 1'b0; pr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ng < 8 && mem_we && !pw) begin seq = {seq[6:0], 1'b1}; ng++; end
      if (ng < 8 && mem_re && !pr) begin seq = {seq[6:0], 1'b0}; ng++; end
      pw = mem_we; pr = mem_re;
    end
    chk("fair count", ng, 8);
    chk("fair order", seq, 8'hAA);

    // Cross completion is ignored
    do_reset();
    wr_req = 1'b1; wr_addr = 32'h40; wr_data = 32'h77;
    @(negedge clk);
    chk("xc mem_we", mem_we, 1);
    read_finished = 1'b1;
    @(negedge clk);
    chk("xc still wr", mem_we, 1);
    chk("xc no ack", wr_ack, 0);
    read_finished = 1'b0; write_finished = 1'b1;
    @(negedge clk);
    chk("xc wr_ack", wr_ack, 1);
    quiet();

    // Watchdog abort and re-grant
    do_reset();
    rd_req = 1'b1; rd_addr = 32'h80;
    repeat (4) @(negedge clk);
    chk("to before", mem_re, 1);
    chk("to err before", timeout_err, 0);
    @(negedge clk);
    chk("to idle", busy, 0);
    chk("to err", timeout_err, 1);
    chk("to no ack", rd_ack, 0);
    chk("model err", e_err, 1);
    @(negedge clk);
    chk("to regrant", mem_re, 1);
    read_finished = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk);
    chk("to rd_ack", rd_ack, 1);
    chk("to data", rd_data, 32'h1234);
    chk("to err sticky", timeout_err, 1);
    quiet();

    // Reset in the middle of a write
    wr_req = 1'b1; wr_addr = 32'h500; wr_data = 32'h9;
    @(negedge clk);
    chk("mr mem_we", mem_we, 1);
    r = 1'b0;
    #1;
    chk("mr mem_we off", mem_we, 0);
    chk("mr busy off", busy, 0);
    chk("mr err off", timeout_err, 0);
    chk("mr addr off", mem_addr, 0);
    chk("mr no ack", wr_ack, 0);
    @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    chk("mr regrant", mem_we, 1);
    chk("mr addr", mem_addr, 32'h500);
    chk("mr wdata", mem_wdata, 32'h9);
    write_finished = 1'b1;
    @(negedge clk);
    chk("mr wr_ack", wr_ack, 1);
    quiet();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = ($urandom_range(0, 599) != 0);
      if (rd_req) begin
        if (rd_ack) begin
          if ($urandom_range(0, 1) != 0) rd_req = 1'b0;
          else rd_addr = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rd_req = 1'b1; rd_addr = $urandom;
      end
      if (wr_req) begin
        if (wr_ack) begin
          if ($urandom_range(0, 1) != 0) wr_req = 1'b0;
          else begin wr_addr = $urandom; wr_data = $urandom; end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        wr_req = 1'b1; wr_addr = $urandom; wr_data = $urandom;
      end
      if (((c / 300) % 2) == 1) begin
        read_finished  = ($urandom_range(0, 9) == 0);
        write_finished = ($urandom_range(0, 9) == 0);
      end else begin
        read_finished  = ($urandom_range(0, 9) < 4);
        write_finished = ($urandom_range(0, 9) < 4);
      end
      mem_rdata = $urandom;
    end
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
